// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment capture block.
//   - segment bit positions within the 7-bit seg bus (bit6=a ... bit0=g)
//   - ASCII constants used by the reverse decoder and buffer reset
//   - settle FSM state encoding
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_QMARK = 8'h3F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        LATCHED = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_capture_if.sv
// seg7_capture_if: frame output handshake.
//   frame_data  : captured ASCII, digit i in bits [8i+7:8i]
//   frame_valid : frame_data holds an unconsumed frame
//   frame_ready : consumer accepts when high together with frame_valid
// master = frame producer (seg7_capture), slave = consumer.
interface seg7_capture_if #(
    parameter int DIGITS = 4
);
    logic [8*DIGITS-1:0] frame_data;
    logic                frame_valid;
    logic                frame_ready;

    modport master (output frame_data, output frame_valid, input frame_ready);
    modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational reverse decode of a 7-segment pattern to ASCII.
//   seg  : pattern, bit6=a ... bit0=g, active-high
//   char : ASCII code; '?' for patterns with no mapping
//   err  : high when the pattern had no mapping
// Where a pattern is ambiguous the digit reading is chosen over a letter and
// uppercase over lowercase, so every pattern has exactly one answer.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [7:0] char,
    output logic       err
);

    always_comb begin
        err  = 1'b0;
        char = CH_QMARK;
        case (seg)
            7'b0000000: char = CH_SPACE;
            7'b0000001: char = CH_DASH;
            // digits
            7'b1111110: char = 8'h30;
            7'b0110000: char = 8'h31;
            7'b1101101: char = 8'h32;
            7'b1111001: char = 8'h33;
            7'b0110011: char = 8'h34;
            7'b1011011: char = 8'h35;
            7'b1011111: char = 8'h36;
            7'b1110000: char = 8'h37;
            7'b1111111: char = 8'h38;
            7'b1111011: char = 8'h39;
            // uppercase letters
            7'b1110111: char = 8'h41; // A
            7'b1001110: char = 8'h43; // C
            7'b1001111: char = 8'h45; // E
            7'b1000111: char = 8'h46; // F
            7'b0110111: char = 8'h48; // H
            7'b0111000: char = 8'h4A; // J
            7'b0001110: char = 8'h4C; // L
            7'b1100111: char = 8'h50; // P
            7'b0111110: char = 8'h55; // U
            7'b0111011: char = 8'h59; // Y
            // lowercase letters with no uppercase/digit lookalike
            7'b0011111: char = 8'h62; // b
            7'b0001101: char = 8'h63; // c
            7'b0111101: char = 8'h64; // d
            7'b0010111: char = 8'h68; // h
            7'b0011101: char = 8'h6F; // o
            7'b0011100: char = 8'h75; // u
            default: begin
                char = CH_QMARK;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: reader side of a multiplexed 7-segment display.
// Watches seg/dig_sel, waits for each digit pattern to hold for STABLE_CYCLES
// consecutive samples, decodes it to ASCII into a per-digit buffer and, when
// every digit has been seen and something changed, offers the frame on frm.
//   clk        : system clock
//   reset_n    : synchronous active-low reset
//   seg        : segment lines, bit6=a ... bit0=g
//   dig_sel    : one-hot digit enable from the scanner
//   frm        : frame handshake (master side)
//   decode_err : sticky, an accepted pattern had no mapping
//   overrun    : sticky, a changed frame was dropped while one was pending
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int CW            = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [6:0]        seg,
    input  logic [DIGITS-1:0] dig_sel,
    seg7_capture_if.master    frm,
    output logic              decode_err,
    output logic              overrun
);

    // Counter value on the edge just before acceptance; the accepting edge
    // takes it to STABLE_CYCLES.
    localparam logic [CW-1:0] ACC_AT = CW'(STABLE_CYCLES - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [DIGITS-1:0]   lat_sel;
    logic [6:0]          lat_seg;
    logic [8*DIGITS-1:0] char_buf;
    logic [DIGITS-1:0]   seen;
    logic                changed;

    logic                onehot, sel_chg, seg_chg, accept;
    logic [7:0]          dec_char, old_char;
    logic                dec_err;
    logic [8*DIGITS-1:0] nxt_buf;
    logic [DIGITS-1:0]   nxt_seen;
    logic                nxt_chg, complete;

    seg7_decode u_dec (
        .seg  (lat_seg),
        .char (dec_char),
        .err  (dec_err)
    );

    assign onehot  = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);
    assign sel_chg = (dig_sel != lat_sel);
    assign seg_chg = (seg != lat_seg);
    // Inputs still match the latched sample, so lat_seg is the current pattern.
    assign accept  = (state == SETTLE) && !sel_chg && !seg_chg && (cnt == ACC_AT);

    // Buffer as it will be after this accept; lat_sel is one-hot here.
    always_comb begin
        nxt_buf  = char_buf;
        old_char = CH_SPACE;
        for (int i = 0; i < DIGITS; i++) begin
            if (lat_sel[i]) begin
                old_char        = char_buf[8*i +: 8];
                nxt_buf[8*i +: 8] = dec_char;
            end
        end
    end

    assign nxt_seen = seen | lat_sel;
    assign nxt_chg  = changed | (dec_char != old_char);
    assign complete = &nxt_seen;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            lat_sel         <= '0;
            lat_seg         <= '0;
            char_buf        <= {DIGITS{CH_SPACE}};
            seen            <= '0;
            changed         <= 1'b0;
            frm.frame_data  <= {DIGITS{CH_SPACE}};
            frm.frame_valid <= 1'b0;
            decode_err      <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            // Transfer; a frame loaded below in the same cycle overrides this.
            if (frm.frame_valid && frm.frame_ready)
                frm.frame_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (onehot) begin
                        state   <= SETTLE;
                        cnt     <= CW'(1);
                        lat_sel <= dig_sel;
                        lat_seg <= seg;
                    end
                end
                SETTLE: begin
                    if (sel_chg || seg_chg) begin
                        if (onehot) begin
                            cnt     <= CW'(1);
                            lat_sel <= dig_sel;
                            lat_seg <= seg;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (accept)
                            state <= LATCHED;
                    end
                end
                LATCHED: begin
                    // seg changes are ignored until the scanner moves on
                    if (sel_chg) begin
                        if (onehot) begin
                            state   <= SETTLE;
                            cnt     <= CW'(1);
                            lat_sel <= dig_sel;
                            lat_seg <= seg;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            if (accept) begin
                char_buf <= nxt_buf;
                if (dec_err)
                    decode_err <= 1'b1;
                if (complete) begin
                    seen    <= '0;
                    changed <= 1'b0;
                    if (nxt_chg) begin
                        if (!frm.frame_valid || frm.frame_ready) begin
                            frm.frame_data  <= nxt_buf;
                            frm.frame_valid <= 1'b1;
                        end else begin
                            // keep the pending frame intact; the new one is lost
                            overrun <= 1'b1;
                        end
                    end
                end else begin
                    seen    <= nxt_seen;
                    changed <= nxt_chg;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] seg;
    logic [3:0] dig_sel;
    logic       decode_err, overrun;

    seg7_capture_if #(.DIGITS(4)) bus ();

    seg7_capture #(.DIGITS(4), .STABLE_CYCLES(16), .CW(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frm        (bus.master),
        .decode_err (decode_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] P0    = 7'b1111110;
    localparam logic [6:0] P1    = 7'b0110000;
    localparam logic [6:0] P2    = 7'b1101101;
    localparam logic [6:0] PA    = 7'b1110111;
    localparam logic [6:0] PDASH = 7'b0000001;
    localparam logic [6:0] PE    = 7'b1001111;
    localparam logic [6:0] PF    = 7'b1000111;
    localparam logic [6:0] PBAD  = 7'b1010101;
    localparam logic [6:0] P8    = 7'b1111111;

    int checks = 0;
    int failures = 0;
    int nframes = 0;
    logic [31:0] last_data = '0;

    // Frames actually transferred to the consumer.
    always @(posedge clk) begin
        if (reset_n === 1'b1 && bus.frame_valid === 1'b1 && bus.frame_ready === 1'b1) begin
            nframes   = nframes + 1;
            last_data = bus.frame_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds the inputs for n clock edges.
    task automatic drive(input logic [3:0] s, input logic [6:0] g, input int n);
        dig_sel = s;
        seg     = g;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] g0, g1, g2, g3);
        drive(4'b0001, g0, 20);
        drive(4'b0010, g1, 20);
        drive(4'b0100, g2, 20);
        drive(4'b1000, g3, 20);
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.frame_ready = 1'b1;
        seg             = '0;
        dig_sel         = '0;
        @(negedge clk);
        repeat (2) begin
            seg     = 7'($urandom);
            dig_sel = 4'($urandom);
            @(negedge clk);
        end
        chk("rst_valid", 32'(bus.frame_valid), 32'd0);
        chk("rst_data", bus.frame_data, 32'h20202020);
        chk("rst_decode_err", 32'(decode_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        drive(4'b0000, 7'b0, 2);

        // First scan: "A210"; valid appears right after the 16th stable sample
        drive(4'b0001, P0, 20);
        drive(4'b0010, P1, 20);
        drive(4'b0100, P2, 20);
        drive(4'b1000, PA, 15);
        chk("scan1_not_yet", 32'(bus.frame_valid), 32'd0);
        drive(4'b1000, PA, 1);
        chk("scan1_valid", 32'(bus.frame_valid), 32'd1);
        chk("scan1_data", bus.frame_data, 32'h41323130);
        drive(4'b1000, PA, 4);
        chk("scan1_frames", 32'(nframes), 32'd1);
        chk("scan1_valid_drop", 32'(bus.frame_valid), 32'd0);

        // Same content again: no frame
        scan(P0, P1, P2, PA);
        chk("repeat_noframe", 32'(nframes), 32'd1);

        // Digit 2 dwell too short: not accepted, frame never completes
        drive(4'b0001, P0, 20);
        drive(4'b0010, P1, 20);
        drive(4'b0100, PDASH, 12);
        drive(4'b1000, PA, 20);
        chk("short_dwell_frames", 32'(nframes), 32'd1);
        chk("short_dwell_valid", 32'(bus.frame_valid), 32'd0);

        // Glitch mid-dwell on digit 2 restarts the settle count
        drive(4'b0001, P0, 20);
        drive(4'b0010, P1, 20);
        drive(4'b0100, PDASH, 10);
        drive(4'b0100, P8, 1);
        drive(4'b0100, PDASH, 15);
        chk("glitch_restart", 32'(bus.frame_valid), 32'd0);
        drive(4'b0100, PDASH, 1);
        chk("glitch_valid", 32'(bus.frame_valid), 32'd1);
        chk("glitch_data", bus.frame_data, 32'h412D3130);
        drive(4'b0100, PDASH, 4);
        chk("glitch_frames", 32'(nframes), 32'd2);

        // Backpressure: second changed frame is dropped, first is held
        bus.frame_ready = 1'b0;
        scan(PE, P1, PDASH, PA);
        chk("bp_valid1", 32'(bus.frame_valid), 32'd1);
        chk("bp_data1", bus.frame_data, 32'h412D3145);
        chk("bp_overrun0", 32'(overrun), 32'd0);
        scan(PF, P1, PDASH, PA);
        chk("bp_valid2", 32'(bus.frame_valid), 32'd1);
        chk("bp_data_held", bus.frame_data, 32'h412D3145);
        chk("bp_overrun1", 32'(overrun), 32'd1);
        bus.frame_ready = 1'b1;
        @(negedge clk);
        bus.frame_ready = 1'b0;
        chk("bp_valid_drop", 32'(bus.frame_valid), 32'd0);
        chk("bp_frames", 32'(nframes), 32'd3);
        chk("bp_last_data", last_data, 32'h412D3145);
        bus.frame_ready = 1'b1;

        // Unmapped pattern becomes '?' and sets the sticky error
        chk("bad_err_before", 32'(decode_err), 32'd0);
        scan(PBAD, P1, PDASH, PA);
        chk("bad_frames", 32'(nframes), 32'd4);
        chk("bad_data", last_data, 32'h412D313F);
        chk("bad_err_set", 32'(decode_err), 32'd1);
        scan(P0, P1, P2, PA);
        chk("good_frames", 32'(nframes), 32'd5);
        chk("good_data", last_data, 32'h41323130);
        chk("bad_err_sticky", 32'(decode_err), 32'd1);

        // Non-one-hot select must never accept
        drive(4'b0011, PA, 40);
        drive(4'b0010, P1, 20);
        drive(4'b0100, P2, 20);
        drive(4'b1000, PA, 20);
        chk("multi_sel_frames", 32'(nframes), 32'd5);
        chk("multi_sel_valid", 32'(bus.frame_valid), 32'd0);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
